// File: rtl/rs_hs_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Package : rs_hs_pkg                                              |
// | Shared helpers for the pipelined handshake receive-side buffer:  |
// | pointer-width function and parameter legality check.             |
// | Rev 1.0 : initial release                                        |
// +------------------------------------------------------------------+
package rs_hs_pkg;

   // Bits needed to encode values 0..n-1, never less than one bit.
   function automatic int clog2_min1(input int n);
      int r;
      r = 0;
      for (int v = 1; v < n; v = v * 2) begin
         r = r + 1;
      end
      return (r < 1) ? 1 : r;
   endfunction

   // The buffer must hold the grace-window words plus two more so that the
   // registered ready has room to react before storage runs out.
   function automatic bit params_ok(input int depth, input int grace);
      return (grace >= 0) && (depth >= grace + 2);
   endfunction

endpackage : rs_hs_pkg
`default_nettype wire

// File: rtl/rs_hs_fwft_regfifo.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module  : rs_hs_fwft_regfifo                                     |
// | First-word-fall-through register FIFO with arbitrary (non power  |
// | of two) depth. Exports occupancy, next occupancy and write-drop. |
// | Rev 1.0 : initial release                                        |
// +------------------------------------------------------------------+
module rs_hs_fwft_regfifo
   import rs_hs_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int DEPTH      = 8
) (
   input  logic                                 clk,
   input  logic                                 reset,
   input  logic                                 i_write,
   input  logic [DATA_WIDTH-1:0]                i_din,
   input  logic                                 i_read,
   output logic [clog2_min1(DEPTH+1)-1:0]       o_count,
   output logic [clog2_min1(DEPTH+1)-1:0]       o_count_next,
   output logic                                 o_wr_drop,
   output logic [DATA_WIDTH-1:0]                o_dout
);

   localparam int c_ptr_w = clog2_min1(DEPTH);
   localparam int c_cnt_w = clog2_min1(DEPTH + 1);
   localparam logic [c_ptr_w-1:0] c_last_ptr = c_ptr_w'(DEPTH - 1);
   localparam logic [c_cnt_w-1:0] c_depth    = c_cnt_w'(DEPTH);

   logic [DATA_WIDTH-1:0] r_mem [DEPTH];
   logic [c_ptr_w-1:0]    r_wptr;
   logic [c_ptr_w-1:0]    r_rptr;
   logic [c_cnt_w-1:0]    r_count;
   logic [c_cnt_w-1:0]    w_count_next;
   logic                  w_rd_fire;
   logic                  w_wr_fire;

   // A read frees a slot in the same cycle, so a full FIFO still accepts a
   // write when it is also being read.
   assign w_rd_fire = i_read & (r_count != '0);
   assign w_wr_fire = i_write & ((r_count < c_depth) | w_rd_fire);

   // Occupancy after this edge, also used by the top for the credit threshold.
   always_comb begin
      w_count_next = r_count;
      if (w_wr_fire && !w_rd_fire) begin
         w_count_next = r_count + 1'b1;
      end else if (!w_wr_fire && w_rd_fire) begin
         w_count_next = r_count - 1'b1;
      end
   end

   // Pointers and occupancy; wrap is explicit because DEPTH may be non-pow2.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         r_count <= w_count_next;
         if (w_wr_fire) begin
            r_wptr <= (r_wptr == c_last_ptr) ? '0 : r_wptr + 1'b1;
         end
         if (w_rd_fire) begin
            r_rptr <= (r_rptr == c_last_ptr) ? '0 : r_rptr + 1'b1;
         end
      end
   end

   // Storage is not reset; a stale entry is never visible because valid
   // comes from the count.
   always_ff @(posedge clk) begin
      if (!reset && w_wr_fire) begin
         r_mem[r_wptr] <= i_din;
      end
   end

   assign o_count      = r_count;
   assign o_count_next = w_count_next;
   assign o_wr_drop    = i_write & ~w_wr_fire;
   assign o_dout       = r_mem[r_rptr];

endmodule : rs_hs_fwft_regfifo
`default_nettype wire

// File: rtl/rs_hs_pipeline_tail_buffer.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module  : rs_hs_pipeline_tail_buffer                             |
// | Receive-side end of a pipelined handshake channel. Absorbs words |
// | still in flight after ready drops, using a credit threshold on   |
// | a FWFT register FIFO; flags any dropped write as sticky overflow.|
// | Rev 1.0 : initial release                                        |
// +------------------------------------------------------------------+
module rs_hs_pipeline_tail_buffer
   import rs_hs_pkg::*;
#(
   parameter int DATA_WIDTH   = 32,
   parameter int DEPTH        = 8,
   parameter int GRACE_PERIOD = 2,
   parameter     __REGION     = ""
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  if_write,
   input  logic [DATA_WIDTH-1:0] if_din,
   output logic                  if_full_n,
   output logic                  if_empty_n,
   input  logic                  if_read,
   output logic [DATA_WIDTH-1:0] if_dout,
   output logic                  overflow
);

   localparam int c_cnt_w = clog2_min1(DEPTH + 1);
   localparam logic [c_cnt_w-1:0] c_credit_lim = c_cnt_w'(DEPTH - GRACE_PERIOD);

   // Refuse to elaborate when the buffer cannot cover the grace window.
   if (!params_ok(DEPTH, GRACE_PERIOD)) begin : g_param_check
      $error("rs_hs_pipeline_tail_buffer: DEPTH must be >= GRACE_PERIOD + 2");
   end

   logic [c_cnt_w-1:0] w_count;
   logic [c_cnt_w-1:0] w_count_next;
   logic               w_wr_drop;
   logic               r_full_n;
   logic               r_overflow;

   rs_hs_fwft_regfifo #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (DEPTH)
   ) u_fifo (
      .clk          (clk),
      .reset        (reset),
      .i_write      (if_write),
      .i_din        (if_din),
      .i_read       (if_read),
      .o_count      (w_count),
      .o_count_next (w_count_next),
      .o_wr_drop    (w_wr_drop),
      .o_dout       (if_dout)
   );

   // Ready is withdrawn while GRACE_PERIOD slots remain, leaving room for
   // the words already travelling through the pipeline stages.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_full_n <= 1'b0;
      end else begin
         r_full_n <= (w_count_next < c_credit_lim);
      end
   end

   // Sticky record that the upstream broke its contract and a word was lost.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_overflow <= 1'b0;
      end else begin
         r_overflow <= r_overflow | w_wr_drop;
      end
   end

   assign if_full_n  = r_full_n;
   assign if_empty_n = (w_count != '0);
   assign overflow   = r_overflow;

endmodule : rs_hs_pipeline_tail_buffer
`default_nettype wire

// File: tb/tb_rs_hs_pipeline_tail_buffer.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module  : tb_rs_hs_pipeline_tail_buffer                          |
// | Self-checking bench: directed vector table, hand sequences for   |
// | grace window / overflow / concurrency / reset, then random       |
// | traffic against a queue-based reference model.                  |
// | Rev 1.0 : initial release                                        |
// +------------------------------------------------------------------+
module tb_rs_hs_pipeline_tail_buffer;

   localparam int DW    = 32;
   localparam int DEPTH = 8;
   localparam int GRACE = 2;

   logic          clk = 1'b0;
   logic          reset;
   logic          if_write;
   logic [DW-1:0] if_din;
   logic          if_full_n;
   logic          if_empty_n;
   logic          if_read;
   logic [DW-1:0] if_dout;
   logic          overflow;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model state: stored words in arrival order plus flag bits.
   logic [DW-1:0] m_q[$];
   bit            m_full_n = 1'b0;
   bit            m_ovf    = 1'b0;

   typedef struct {
      bit          rst;
      bit          wr;
      logic [31:0] din;
      bit          rd;
      bit          e_empty_n;
      bit          e_full_n;
      bit          e_ovf;
      logic [31:0] e_dout;
   } vec_t;

   vec_t vecs[$];

   rs_hs_pipeline_tail_buffer #(
      .DATA_WIDTH   (DW),
      .DEPTH        (DEPTH),
      .GRACE_PERIOD (GRACE),
      .__REGION     ("")
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .if_write   (if_write),
      .if_din     (if_din),
      .if_full_n  (if_full_n),
      .if_empty_n (if_empty_n),
      .if_read    (if_read),
      .if_dout    (if_dout),
      .overflow   (overflow)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   // Apply one cycle of inputs, advance the model by the transfer rules, and
   // come back on the falling edge where the outputs are settled.
   task automatic step(input bit rst, input bit wr, input logic [DW-1:0] din, input bit rd);
      bit rd_ok, wr_ok;
      reset    = rst;
      if_write = wr;
      if_din   = din;
      if_read  = rd;
      @(posedge clk);
      if (rst) begin
         m_q.delete();
         m_ovf    = 1'b0;
         m_full_n = 1'b0;
      end else begin
         rd_ok = rd && (m_q.size() != 0);
         wr_ok = wr && ((m_q.size() < DEPTH) || rd_ok);
         if (rd_ok) void'(m_q.pop_front());
         if (wr_ok) m_q.push_back(din);
         if (wr && !wr_ok) m_ovf = 1'b1;
         m_full_n = (m_q.size() < DEPTH - GRACE);
      end
      @(negedge clk);
   endtask

   task automatic chk_model(input string tag);
      chk({tag, ".empty_n"}, DW'(if_empty_n), DW'(m_q.size() != 0));
      chk({tag, ".full_n"},  DW'(if_full_n),  DW'(m_full_n));
      chk({tag, ".ovf"},     DW'(overflow),   DW'(m_ovf));
      if (m_q.size() != 0) chk({tag, ".dout"}, if_dout, m_q[0]);
   endtask

   initial begin
      reset    = 1'b1;
      if_write = 1'b0;
      if_din   = '0;
      if_read  = 1'b0;
      @(negedge clk);

      // ---- Directed table: reset, latency, empty corner cases ----
      //            rst wr din           rd  empty full ovf dout
      vecs.push_back('{1, 0, 32'h0,        0, 0, 0, 0, 32'h0});
      vecs.push_back('{1, 1, 32'h99,       1, 0, 0, 0, 32'h0});
      vecs.push_back('{1, 0, 32'h0,        0, 0, 0, 0, 32'h0});
      vecs.push_back('{0, 0, 32'h0,        0, 0, 1, 0, 32'h0});
      vecs.push_back('{0, 1, 32'hA5A50001, 0, 1, 1, 0, 32'hA5A50001});
      vecs.push_back('{0, 0, 32'h0,        1, 0, 1, 0, 32'h0});
      vecs.push_back('{0, 1, 32'h11,       1, 1, 1, 0, 32'h11});
      vecs.push_back('{0, 0, 32'h0,        1, 0, 1, 0, 32'h0});
      vecs.push_back('{0, 0, 32'h0,        1, 0, 1, 0, 32'h0});
      vecs.push_back('{1, 1, 32'h22,       0, 0, 0, 0, 32'h0});
      vecs.push_back('{0, 0, 32'h0,        0, 0, 1, 0, 32'h0});
      foreach (vecs[i]) begin
         step(vecs[i].rst, vecs[i].wr, vecs[i].din, vecs[i].rd);
         chk($sformatf("vec%0d.empty_n", i), DW'(if_empty_n), DW'(vecs[i].e_empty_n));
         chk($sformatf("vec%0d.full_n", i),  DW'(if_full_n),  DW'(vecs[i].e_full_n));
         chk($sformatf("vec%0d.ovf", i),     DW'(overflow),   DW'(vecs[i].e_ovf));
         if (vecs[i].e_empty_n) chk($sformatf("vec%0d.dout", i), if_dout, vecs[i].e_dout);
      end

      // ---- Grace window: 8 writes, ready drops at occupancy 6 ----
      for (int i = 1; i <= 8; i++) begin
         step(0, 1, DW'(i), 0);
         chk($sformatf("grace.full_n.w%0d", i), DW'(if_full_n), DW'(i < 6));
         chk_model("grace");
      end
      chk("grace.ovf_after_8", DW'(overflow), 32'd0);

      // ---- Overflow: write at full is dropped and sticks ----
      step(0, 1, 32'hDEAD, 0);
      chk("ovf.set", DW'(overflow), 32'd1);
      chk("ovf.head_unchanged", if_dout, 32'd1);
      for (int i = 1; i <= 8; i++) begin
         chk($sformatf("drain.dout%0d", i), if_dout, DW'(i));
         step(0, 0, '0, 1);
         chk_model("drain");
      end
      chk("ovf.sticky", DW'(overflow), 32'd1);
      chk("drain.empty", DW'(if_empty_n), 32'd0);
      step(1, 0, '0, 0);
      step(0, 0, '0, 0);
      chk("ovf.cleared", DW'(overflow), 32'd0);

      // ---- Full concurrency: read+write at full with pointer wrap ----
      for (int i = 0; i < 8; i++) step(0, 1, 32'h1000 + DW'(i), 0);
      for (int i = 8; i < 28; i++) begin
         chk($sformatf("conc.dout%0d", i), if_dout, 32'h1000 + DW'(i - 8));
         step(0, 1, 32'h1000 + DW'(i), 1);
         chk_model("conc");
      end
      chk("conc.ovf", DW'(overflow), 32'd0);

      // ---- Mid-operation reset with a write presented ----
      step(1, 0, '0, 0);
      step(0, 0, '0, 0);
      for (int i = 0; i < 5; i++) step(0, 1, 32'h2000 + DW'(i), 0);
      step(1, 1, 32'hBAD, 0);
      chk("mrst.empty_n", DW'(if_empty_n), 32'd0);
      chk("mrst.full_n0", DW'(if_full_n), 32'd0);
      step(0, 1, 32'h3000, 0);
      chk("mrst.full_n1", DW'(if_full_n), 32'd1);
      chk("mrst.first", if_dout, 32'h3000);
      step(0, 0, '0, 1);
      chk("mrst.empty_after", DW'(if_empty_n), 32'd0);

      // ---- Random traffic against the model ----
      for (int i = 0; i < 3000; i++) begin
         step(($urandom_range(0, 199) == 0), $urandom_range(0, 1) == 1,
              DW'($urandom), $urandom_range(0, 2) != 0);
         chk_model($sformatf("rnd%0d", i));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule : tb_rs_hs_pipeline_tail_buffer
`default_nettype wire
